// File: rtl/vector_serialize.sv
// Buffers 64-bit words in a small FIFO and streams each one out as eight bytes, MSB first.
// Also flags nonzero pad fields in [31:24] and counts fully emitted words.
module vector_serialize #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        pad_err,
  output logic [15:0] word_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  state_t        r_state, w_next_state;
  logic [63:0]   r_shift;
  logic [2:0]    r_idx;
  logic          r_pad;
  logic [15:0]   r_word_count;
  logic          w_push, w_pop, w_empty, w_hs, w_last;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign in_ready = rst && (r_count != CNT_FULL);
  assign w_push   = in_valid && in_ready;
  assign w_empty  = (r_count == '0);
  assign w_last   = (r_state == S_SHIFT) && (r_idx == 3'd7);
  assign w_hs     = out_valid && out_ready;

  assign out_valid  = (r_state == S_SHIFT);
  assign out_data   = (r_state == S_SHIFT) ? r_shift[{3'd7 - r_idx, 3'b000} +: 8] : 8'h00;
  assign out_last   = w_last;
  assign pad_err    = r_pad;
  assign word_count = r_word_count;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_next_state = S_SHIFT;
        w_pop        = 1'b1;
      end
      S_SHIFT: if (w_hs && w_last) begin
        // Reload straight from the FIFO so consecutive words have no bubble.
        if (!w_empty) w_pop = 1'b1;
        else          w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_idx        <= '0;
      r_pad        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_shift <= r_mem[r_rptr];
        r_idx   <= 3'd0;
      end else if (w_hs) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_push && (in_data[31:24] != 8'h00)) r_pad <= 1'b1;
      if (w_hs && w_last) r_word_count <= r_word_count + 16'd1;
    end
  end
endmodule

// File: doc/vector_serialize.md
# vector_serialize

Downstream consumer of the 64-bit vector-append word stage. Accepts 64-bit words through a valid/ready handshake, buffers them in a small FIFO, and emits each word as eight bytes, most-significant byte first, on a byte-wide valid/ready stream. It also checks that the 8-bit zero-pad field (bits [31:24]) of each accepted word is zero, and counts words it has fully emitted.

## Interface
Parameters:
- DEPTH, 2: word FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_data  in  64  upstream word: [63:32] byte-reversed payload, [31:24] zero pad, [23:0] field.
- in_ready  out  1  FIFO can accept a word this cycle.
- out_valid  out  1  out_data holds a valid byte.
- out_data  out  8  current byte.
- out_last  out  1  current byte is byte 7 (in_data[7:0]) of its word.
- out_ready  in  1  downstream accepts the byte.
- pad_err  out  1  sticky flag: an accepted word had a nonzero [31:24].
- word_count  out  16  number of words whose last byte has been handshaken; wraps modulo 2^16.

## Operation
- Input handshake: a word is written when in_valid && in_ready at the clock edge.
  - in_ready = !rst_active && (fifo_count < DEPTH).
  - in_ready has no combinational dependence on out_ready or on pops. When the FIFO is full, in_ready=0 even if a pop happens in the same cycle.
- FIFO holds words in arrival order, with read and write pointers that wrap modulo DEPTH.
  - A push and a pop may occur in the same cycle. In that case fifo_count is unchanged.
- The shifter register and 3-bit byte index form two states:
  - IDLE: no word loaded; out_valid=0.
  - SHIFT: word loaded; out_valid=1.
- State transitions:
  - IDLE → SHIFT: FIFO non-empty. Pop the head word into the shifter and set index=0.
  - SHIFT, byte handshake (out_valid && out_ready) with index<7: index+1.
  - SHIFT, handshake at index 7, FIFO non-empty: reload from the FIFO in the same edge with index=0. There is no bubble between words.
  - SHIFT, handshake at index 7, FIFO empty: → IDLE.
  - SHIFT with out_ready=0: out_data, out_last and index hold stable.
- Byte order: byte k = word[63-8k : 56-8k]. Byte 0 is [63:56] and byte 7 is [7:0].
- Output decode: out_data = shifter byte[index] in SHIFT, and 0 in IDLE. out_last = (index==7) in SHIFT.
- pad_err is set at the push edge of any word with in_data[31:24] != 0. It clears only on reset. The word is still serialized unchanged.
- word_count increments by 1 on each handshake with out_last=1, and wraps from 0xFFFF to 0x0000.

## Timing
- Reset (rst=0 at an edge) clears:
  - FIFO: emptied, pointers 0.
  - State → IDLE, index 0.
  - out_valid=0, out_data=0, out_last=0, pad_err=0, word_count=0.
- While rst=0, in_ready=0.
- After reset: with rst=1, in_ready=1 in the first cycle following the reset edge.
- Reset mid-word: any partial word and all buffered words are discarded. No byte of them appears after reset, and word_count does not increment for them.
- Latency, empty block: push at edge E0; the shifter loads at E1; out_valid=1 with byte 0 during the cycle after E1. The minimum is 2 edges from accept to first byte.
- Throughput: 1 byte per cycle while out_ready=1. A continuous input stream sustains 8 cycles per word with zero idle cycles between words.
- Back-pressure: with out_ready=0, the FIFO fills to DEPTH and in_ready then deasserts. Any in_valid offered while in_ready=0 is not taken.
- All outputs are registered, or decoded only from registered state.

## Test plan
- Single word: rst pulse low, then push 0x04030201_00ABCDEF with out_ready=1.
  - out_valid rises 2 edges after the push.
  - Bytes 04,03,02,01,00,AB,CD,EF are emitted on consecutive cycles, with out_last only on EF.
  - word_count ends at 1 and pad_err stays 0.
- Back-to-back: push 3 words continuously with out_ready=1.
  - Expect 24 consecutive valid bytes with no gap cycle, out_last every 8th byte, and word_count=3.
- Back-pressure: hold out_ready=0 and offer 4 words.
  - Exactly DEPTH+1=3 words are accepted: DEPTH into the FIFO, plus 1 in the shifter after it loads.
  - in_ready stays 0 for the 4th word until bytes drain.
  - out_data holds 0x04 (byte 0) stable while stalled.
- Pad check: push 0x00000000_7F000000.
  - pad_err=1 from the edge after the push, and it stays set.
  - All 8 bytes are still emitted (00,00,00,00,7F,00,00,00).
- Reset mid-word: assert rst=0 after byte 3 of a word has been handshaken, with one more word buffered.
  - Next cycle: out_valid=0, word_count=0, in_ready=0 during reset.
  - No bytes of the old words appear after release.
- Counter wrap: preload word_count to 0xFFFF (force or 65535 words) and emit one word → word_count=0x0000.
